// File: rtl/dla_kpe_acc_seq.sv
// dla_kpe_acc_seq: KPE lane accumulation sequencer with saturating 24-bit or dual 12-bit adds.
// Optional sticky saturation output enabled by DLA_KPE_ACC_SEQ_SAT_FLAG_EN.
package dla_kpe_pkg;
  typedef enum logic [1:0] {PREC_2, PREC_4, PREC_8, PREC_16} precision_ifmap_e;
endpackage

module dla_kpe_acc_seq
  import dla_kpe_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_acc_len,
  input  logic [23:0]      cfg_init,
  input  precision_ifmap_e stgr_precision_ifmap,
  input  logic             psum_valid,
  output logic             psum_ready,
  input  logic [23:0]      psum_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_data,
  output logic             busy,
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
  output logic             out_sat,
`endif
  output logic             done
);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;
  state_e           state_q, state_d;
  logic [23:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  precision_ifmap_e prec_q, prec_d;
  logic             done_q, done_d;
  logic [23:0]      s24, sum;
  logic [11:0]      sh, sl;
  logic             o24, oh, ol, dual;
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
  logic             sat_q, sat_d;
`endif
  // Overflow is detected per lane: same operand signs, different result sign.
  always_comb begin
    s24 = acc_q + psum_data;
    sh = acc_q[23:12] + psum_data[23:12];
    sl = acc_q[11:0] + psum_data[11:0];
    o24 = (acc_q[23] == psum_data[23]) && (s24[23] != acc_q[23]);
    oh = (acc_q[23] == psum_data[23]) && (sh[11] != acc_q[23]);
    ol = (acc_q[11] == psum_data[11]) && (sl[11] != acc_q[11]);
    dual = prec_q != PREC_16;
    sum = dual ? {oh ? (acc_q[23] ? 12'h800 : 12'h7FF) : sh,
                  ol ? (acc_q[11] ? 12'h800 : 12'h7FF) : sl}
               : (o24 ? (acc_q[23] ? 24'h800000 : 24'h7FFFFF) : s24);
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    prec_d = prec_q;
    done_d = 1'b0;
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
    sat_d = sat_q;
`endif
    case (state_q)
      IDLE: if (cfg_start) begin
        len_d = cfg_acc_len;
        prec_d = stgr_precision_ifmap;
        acc_d = cfg_init;
        cnt_d = '0;
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
        sat_d = 1'b0;
`endif
        state_d = (cfg_acc_len != '0) ? ACC : OUT;
      end
      ACC: if (psum_valid) begin
        acc_d = sum;
        cnt_d = cnt_q + LEN_W'(1);
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
        sat_d = sat_q | (dual ? (oh | ol) : o24);
`endif
        state_d = (cnt_q == len_q - LEN_W'(1)) ? OUT : ACC;
      end
      OUT: if (out_ready) begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      prec_q <= PREC_16;
      done_q <= 1'b0;
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
      sat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      prec_q <= prec_d;
      done_q <= done_d;
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
      sat_q <= sat_d;
`endif
    end
  end
  assign psum_ready = state_q == ACC;
  assign out_valid = state_q == OUT;
  assign out_data = acc_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
  assign out_sat = sat_q;
`endif
endmodule

// File: tb/tb_dla_kpe_acc_seq.sv
// tb_dla_kpe_acc_seq: directed self-checking bench for dla_kpe_acc_seq.
module tb_dla_kpe_acc_seq;
  import dla_kpe_pkg::*;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic [9:0]       cfg_acc_len = '0;
  logic [23:0]      cfg_init = '0;
  precision_ifmap_e stgr_precision_ifmap = PREC_16;
  logic             psum_valid = 1'b0;
  logic             psum_ready;
  logic [23:0]      psum_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [23:0]      out_data;
  logic             busy;
  logic             done;
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
  logic             out_sat;
`endif
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  dla_kpe_acc_seq #(.LEN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_acc_len(cfg_acc_len),
    .cfg_init(cfg_init), .stgr_precision_ifmap(stgr_precision_ifmap),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy),
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
    .out_sat(out_sat),
`endif
    .done(done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [9:0] len, input logic [23:0] init, input precision_ifmap_e p);
    cfg_acc_len = len;
    cfg_init = init;
    stgr_precision_ifmap = p;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [23:0] d, output int waits);
    psum_valid = 1'b1;
    psum_data = d;
    waits = 0;
    while (!psum_ready && waits < 50) begin
      tick;
      waits++;
    end
    tick;
  endtask

  task automatic take_out(output logic d1, output logic b1);
    for (int i = 0; i < 50 && !out_valid; i++) tick;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    d1 = done;
    b1 = busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    checks++;
    if ({psum_ready, out_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/vld/busy/done=%b want 0000", {psum_ready, out_valid, busy, done});
    end
    checks++;
    if (out_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 000000", out_data);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_accumulate;
    int w, wt;
    int dc;
    logic d1, b1;
    wt = 0;
    start_job(10'd4, 24'h0, PREC_16);
    checks++;
    if (psum_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_to_ready got %b want 1", psum_ready);
    end
    for (int i = 1; i <= 4; i++) begin
      send(24'(i), w);
      wt += w;
    end
    psum_valid = 1'b0;
    checks++;
    if (wt !== 0) begin
      errors++;
      $display("FAIL throughput stalls got %0d want 0", wt);
    end
    checks++;
    if ({out_valid, psum_ready} !== 2'b10) begin
      errors++;
      $display("FAIL acc_out_timing got vld/rdy=%b want 10", {out_valid, psum_ready});
    end
    checks++;
    if (out_data !== 24'h00000A) begin
      errors++;
      $display("FAIL acc_sum got %h want 00000a", out_data);
    end
    dc = done_cnt;
    take_out(d1, b1);
    checks++;
    if ({d1, b1} !== 2'b10) begin
      errors++;
      $display("FAIL acc_done got done/busy=%b want 10", {d1, b1});
    end
    tick;
    checks++;
    if (done_cnt - dc !== 1 || done !== 1'b0) begin
      errors++;
      $display("FAIL acc_done_pulse got count %0d done %b want 1 0", done_cnt - dc, done);
    end
  endtask

  task automatic test_saturate;
    int w;
    logic d1, b1;
    start_job(10'd2, 24'h7FFFF0, PREC_16);
    send(24'h000010, w);
    send(24'h000005, w);
    psum_valid = 1'b0;
    checks++;
    if (out_data !== 24'h7FFFFF) begin
      errors++;
      $display("FAIL sat16_pos got %h want 7fffff", out_data);
    end
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
    checks++;
    if (out_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat16_flag got %b want 1", out_sat);
    end
`endif
    take_out(d1, b1);
    start_job(10'd1, 24'h7FE001, PREC_8);
    send(24'h002FFF, w);
    psum_valid = 1'b0;
    checks++;
    if (out_data !== 24'h7FF000) begin
      errors++;
      $display("FAIL dual_pos got %h want 7ff000", out_data);
    end
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
    checks++;
    if (out_sat !== 1'b1) begin
      errors++;
      $display("FAIL dual_flag got %b want 1", out_sat);
    end
`endif
    take_out(d1, b1);
    start_job(10'd1, 24'h800800, PREC_4);
    send(24'hFFFFFF, w);
    psum_valid = 1'b0;
    checks++;
    if (out_data !== 24'h800800) begin
      errors++;
      $display("FAIL dual_neg got %h want 800800", out_data);
    end
    take_out(d1, b1);
  endtask

  task automatic test_len0;
    logic d1, b1;
    start_job(10'd0, 24'h123456, PREC_16);
    checks++;
    if ({out_valid, psum_ready} !== 2'b10) begin
      errors++;
      $display("FAIL len0_timing got vld/rdy=%b want 10", {out_valid, psum_ready});
    end
    checks++;
    if (out_data !== 24'h123456) begin
      errors++;
      $display("FAIL len0_data got %h want 123456", out_data);
    end
`ifdef DLA_KPE_ACC_SEQ_SAT_FLAG_EN
    checks++;
    if (out_sat !== 1'b0) begin
      errors++;
      $display("FAIL len0_flag_clear got %b want 0", out_sat);
    end
`endif
    take_out(d1, b1);
    checks++;
    if ({d1, b1, psum_ready} !== 3'b100) begin
      errors++;
      $display("FAIL len0_done got done/busy/rdy=%b want 100", {d1, b1, psum_ready});
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] d [3];
    logic [7:0] pat;
    logic rb, d1, b1;
    int idx, dc;
    logic [23:0] held;
    d = '{24'd1, 24'd2, 24'd3};
    pat = 8'b0110_1001;
    idx = 0;
    start_job(10'd3, 24'd100, PREC_16);
    for (int c = 0; c < 40 && idx < 3; c++) begin
      psum_valid = pat[c % 8];
      psum_data = d[idx];
      cfg_init = 24'hABCDEF;
      cfg_acc_len = 10'd1;
      cfg_start = (c == 1);
      rb = psum_ready;
      tick;
      cfg_start = 1'b0;
      if (psum_valid && rb) idx++;
    end
    psum_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'd106) begin
      errors++;
      $display("FAIL bp_sum got vld %b data %h want 1 00006a", out_valid, out_data);
    end
    held = out_data;
    dc = done_cnt;
    for (int i = 0; i < 5; i++) begin
      cfg_start = (i == 2);
      tick;
      cfg_start = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got vld %b data %h want 1 %h", i, out_valid, out_data, held);
      end
    end
    take_out(d1, b1);
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || done_cnt - dc !== 1) begin
      errors++;
      $display("FAIL bp_ignored_start got busy %b dones %0d want 0 1", busy, done_cnt - dc);
    end
  endtask

  task automatic test_reset_midjob;
    int w;
    logic d1, b1;
    start_job(10'd6, 24'h0, PREC_16);
    send(24'd5, w);
    send(24'd5, w);
    psum_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({psum_ready, out_valid, busy, done} !== 4'b0 || out_data !== 24'h0) begin
      errors++;
      $display("FAIL async_reset got rdy/vld/busy/done=%b data %h want 0000 000000",
               {psum_ready, out_valid, busy, done}, out_data);
    end
    #2 rst_n = 1'b1;
    tick;
    start_job(10'd2, 24'h000100, PREC_8);
    send(24'h001001, w);
    send(24'h002002, w);
    psum_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h003103) begin
      errors++;
      $display("FAIL post_reset_job got vld %b data %h want 1 003103", out_valid, out_data);
    end
    take_out(d1, b1);
  endtask

  initial begin
    test_reset;
    test_accumulate;
    test_saturate;
    test_len0;
    test_back_to_back;
    test_reset_midjob;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
